// File: rtl/chirp_monitor.sv
// ---------------------------------------------------------------------------
// chirp_monitor
//
// Measures the interval, in clk edges, between consecutive rising edges of a
// single-bit chirp waveform. Each interval is classified against the one
// before it (longer / shorter / equal). A chirp is flagged once the interval
// has moved in the same direction for DETECT_N consecutive steps. If the
// interval counter saturates without a rising edge, measurement is abandoned
// and a timeout pulse is emitted.
//
// Parameters:
//   WIDTH     interval counter / period width; longest interval 2^WIDTH-1
//   DETECT_N  same-direction steps needed to raise chirp (1..15)
//
// Ports:
//   clk      in   rising-edge clock
//   syn_rst  in   synchronous active-high reset, overrides everything
//   in       in   chirp waveform, synchronous to clk
//   period   out  last measured interval (held between valid pulses)
//   valid    out  one-cycle pulse when period/dir/chirp update
//   dir      out  00 first, 01 longer, 10 shorter, 11 equal
//   chirp    out  high while the same-direction run length >= DETECT_N
//   timeout  out  one-cycle pulse when the counter saturates
// ---------------------------------------------------------------------------
module chirp_monitor #(
  parameter int WIDTH    = 8,
  parameter int DETECT_N = 3
) (
  input  logic             clk,
  input  logic             syn_rst,
  input  logic             in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic [1:0]       dir,
  output logic             chirp,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  typedef enum logic [1:0] {
    DIR_FIRST   = 2'b00,
    DIR_LONGER  = 2'b01,
    DIR_SHORTER = 2'b10,
    DIR_EQUAL   = 2'b11
  } dir_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]       RUN_MAX = 4'(DETECT_N);

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] prev_q;
  logic             in_prev_q;
  logic             have_prev_q;
  logic [3:0]       run_q;
  logic [WIDTH-1:0] period_q;
  logic             valid_q;
  dir_t             dir_q;
  logic             chirp_q;
  logic             timeout_q;

  logic             rise;
  dir_t             dir_d;
  logic [3:0]       run_d;

  // in_prev_q resets high, so a line already high out of reset is not an edge.
  assign rise = in & ~in_prev_q;

  // Classification of the interval that ends on this rise.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    dir_d = DIR_FIRST;
    run_d = '0;
    if (have_prev_q) begin
      if (cnt_q > prev_q)      dir_d = DIR_LONGER;
      else if (cnt_q < prev_q) dir_d = DIR_SHORTER;
      else                     dir_d = DIR_EQUAL;
    end
    if (dir_d == DIR_LONGER || dir_d == DIR_SHORTER) begin
      if (dir_d == dir_q) begin
        // Saturate so the run length stays within its 4-bit register.
        run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
      end else begin
        run_d = 4'd1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= '0;
      in_prev_q   <= 1'b1;
      have_prev_q <= 1'b0;
      run_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      dir_q       <= DIR_FIRST;
      chirp_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      in_prev_q <= in;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            state_q <= MEAS;
            cnt_q   <= WIDTH'(1);
          end
        end
        MEAS: begin
          // A rise on the saturated count still wins over the timeout.
          if (rise) begin
            period_q    <= cnt_q;
            valid_q     <= 1'b1;
            cnt_q       <= WIDTH'(1);
            prev_q      <= cnt_q;
            dir_q       <= dir_d;
            run_q       <= run_d;
            chirp_q     <= (run_d >= RUN_MAX);
            have_prev_q <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + WIDTH'(1);
          end else begin
            // period and dir deliberately hold their last values.
            timeout_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            have_prev_q <= 1'b0;
            run_q       <= '0;
            chirp_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign dir     = dir_q;
  assign chirp   = chirp_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_chirp_monitor.sv
// ---------------------------------------------------------------------------
// tb_chirp_monitor
//
// Drives chirp_monitor (WIDTH=8, DETECT_N=3) with directed interval patterns
// and randomized waveforms. A behavioural model tracks rising-edge times and
// classifies intervals with plain arithmetic; each scenario task compares the
// DUT against both the model and hand-derived constants.
// ---------------------------------------------------------------------------
module tb_chirp_monitor;

  localparam int W      = 8;
  localparam int DN     = 3;
  localparam int MAXCNT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         syn_rst;
  logic         in;
  logic [W-1:0] period;
  logic         valid;
  logic [1:0]   dir;
  logic         chirp;
  logic         timeout;

  chirp_monitor #(.WIDTH(W), .DETECT_N(DN)) dut (
    .clk     (clk),
    .syn_rst (syn_rst),
    .in      (in),
    .period  (period),
    .valid   (valid),
    .dir     (dir),
    .chirp   (chirp),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: time since the last rise, previous interval, trend.
  bit m_in_prev, m_meas, m_have_prev, m_valid, m_timeout, m_chirp;
  int m_age, m_prev_iv, m_dir, m_run, m_period;

  // Observations gathered while stepping.
  int  cyc = 0;
  int  got_p[$], got_d[$], got_c[$], got_t[$];
  int  n_timeout, t_timeout, n_diverge, first_div_cyc, n_valid_total;
  bit  both_seen;
  logic [W+4:0] div_got, div_exp;

  task automatic model_edge(input bit v, input bit r);
    bit rise;
    if (r) begin
      m_in_prev = 1; m_meas = 0; m_have_prev = 0; m_valid = 0; m_timeout = 0;
      m_chirp = 0; m_age = 0; m_prev_iv = 0; m_dir = 0; m_run = 0; m_period = 0;
      return;
    end
    rise = v && !m_in_prev;
    m_in_prev = v;
    m_valid = 0;
    m_timeout = 0;
    if (!m_meas) begin
      if (rise) begin m_meas = 1; m_age = 0; end
    end else begin
      m_age++;
      if (rise) begin
        int nd;
        m_period = m_age;
        m_valid  = 1;
        if (!m_have_prev)          nd = 0;
        else if (m_age > m_prev_iv) nd = 1;
        else if (m_age < m_prev_iv) nd = 2;
        else                        nd = 3;
        if (nd == 1 || nd == 2) m_run = (nd == m_dir) ? ((m_run + 1 > DN) ? DN : m_run + 1) : 1;
        else                    m_run = 0;
        m_dir = nd;
        m_chirp = (m_run >= DN);
        m_prev_iv = m_age;
        m_have_prev = 1;
        m_age = 0;
      end else if (m_age == MAXCNT) begin
        m_timeout = 1; m_meas = 0; m_have_prev = 0; m_run = 0; m_chirp = 0;
      end
    end
  endtask

  task automatic clear_obs();
    got_p.delete(); got_d.delete(); got_c.delete(); got_t.delete();
    n_timeout = 0; t_timeout = -1;
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // sample outputs 1 time unit later.
  task automatic step(input bit v, input bit r = 0);
    @(negedge clk);
    in = v;
    syn_rst = r;
    @(posedge clk);
    model_edge(v, r);
    #1;
    cyc++;
    if (valid) begin
      got_p.push_back(int'(period)); got_d.push_back(int'(dir));
      got_c.push_back(int'(chirp));  got_t.push_back(cyc);
      n_valid_total++;
    end
    if (timeout) begin n_timeout++; t_timeout = cyc; end
    if (valid && timeout) both_seen = 1;
    if ({period, valid, dir, chirp, timeout} !==
        {W'(m_period), m_valid, 2'(m_dir), m_chirp, m_timeout}) begin
      if (n_diverge == 0) begin
        first_div_cyc = cyc;
        div_got = {period, valid, dir, chirp, timeout};
        div_exp = {W'(m_period), m_valid, 2'(m_dir), m_chirp, m_timeout};
      end
      n_diverge++;
    end
  endtask

  // Next rise lands p edges after the previous one.
  task automatic gap(input int p);
    repeat (p - 1) step(0);
    step(1);
  endtask

  task automatic do_reset();
    step(0, 1);
    step(0, 1);
    step(0);
    clear_obs();
  endtask

  task automatic check_model(input string name);
    checks++;
    if (n_diverge !== 0) begin
      errors++;
      $display("FAIL %s model: %0d diverging cycles, first at cyc %0d got %h exp %h",
               name, n_diverge, first_div_cyc, div_got, div_exp);
    end
    n_diverge = 0;
  endtask

  task automatic check_seq(input string name, input int n, input int ep[8],
                           input int ed[8], input int ec[8]);
    checks++;
    if (got_p.size() !== n) begin
      errors++;
      $display("FAIL %s valid_count: got %0d exp %0d", name, got_p.size(), n);
      return;
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_p[i] !== ep[i] || got_d[i] !== ed[i] || got_c[i] !== ec[i]) begin
        errors++;
        $display("FAIL %s valid[%0d]: got p=%0d d=%0d c=%0d exp p=%0d d=%0d c=%0d",
                 name, i, got_p[i], got_d[i], got_c[i], ep[i], ed[i], ec[i]);
      end
    end
  endtask

  task automatic test_reset();
    step(1, 1);
    checks++;
    if ({period, valid, dir, chirp, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h exp 0", {period, valid, dir, chirp, timeout});
    end
    clear_obs();
    repeat (20) step(1);
    repeat (3) step(0);
    repeat (5) step(1);
    checks++;
    if (got_p.size() !== 0 || {period, dir, chirp, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_no_valid: got valids=%0d outs=%h exp 0 0",
               got_p.size(), {period, dir, chirp, timeout});
    end
    check_model("reset");
  endtask

  task automatic test_square();
    int ep[8] = '{10, 10, 10, 10, 0, 0, 0, 0};
    int ed[8] = '{0, 3, 3, 3, 0, 0, 0, 0};
    int ec[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    repeat (5) begin repeat (5) step(1); repeat (5) step(0); end
    check_seq("square", 4, ep, ed, ec);
    for (int i = 1; i < got_t.size(); i++) begin
      checks++;
      if (got_t[i] - got_t[i-1] !== 10) begin
        errors++;
        $display("FAIL square_spacing[%0d]: got %0d exp 10", i, got_t[i] - got_t[i-1]);
      end
    end
    check_model("square");
  endtask

  task automatic test_ramp();
    int ep[8] = '{4, 5, 6, 7, 3, 0, 0, 0};
    int ed[8] = '{0, 1, 1, 1, 2, 0, 0, 0};
    int ec[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    do_reset();
    step(1);
    gap(4); gap(5); gap(6); gap(7); gap(3);
    step(0);
    check_seq("ramp", 5, ep, ed, ec);
    check_model("ramp");
  endtask

  task automatic test_boundary();
    int rise_cyc;
    do_reset();
    step(1);
    gap(MAXCNT);
    step(0);
    checks++;
    if (got_p.size() !== 1 || (got_p.size() == 1 && got_p[0] !== MAXCNT) || n_timeout !== 0) begin
      errors++;
      $display("FAIL max_interval: got valids=%0d p=%0d timeouts=%0d exp 1 %0d 0",
               got_p.size(), (got_p.size() > 0) ? got_p[0] : -1, n_timeout, MAXCNT);
    end
    do_reset();
    step(1);
    rise_cyc = cyc;
    repeat (300) step(0);
    // The saturating counter hits its ceiling 2^W-1 edges after the rise.
    checks++;
    if (n_timeout !== 1 || t_timeout - rise_cyc !== MAXCNT || got_p.size() !== 0) begin
      errors++;
      $display("FAIL timeout: got count=%0d delay=%0d valids=%0d exp 1 %0d 0",
               n_timeout, t_timeout - rise_cyc, got_p.size(), MAXCNT);
    end
    step(1);
    checks++;
    if (got_p.size() !== 0) begin
      errors++;
      $display("FAIL restart_rise: got valids=%0d exp 0", got_p.size());
    end
    gap(7);
    checks++;
    if (got_p.size() !== 1 || (got_p.size() == 1 && (got_d[0] !== 0 || got_p[0] !== 7))) begin
      errors++;
      $display("FAIL after_timeout: got valids=%0d d=%0d p=%0d exp 1 0 7", got_p.size(),
               (got_p.size() > 0) ? got_d[0] : -1, (got_p.size() > 0) ? got_p[0] : -1);
    end
    check_model("boundary");
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1); gap(4); gap(5);
    repeat (5) step(0);
    clear_obs();
    step(1, 1);
    checks++;
    if (got_p.size() !== 0 || {period, valid, dir, chirp, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_on_rise: got valids=%0d outs=%h exp 0 0",
               got_p.size(), {period, valid, dir, chirp, timeout});
    end
    step(0); step(0);
    step(1);
    checks++;
    if (got_p.size() !== 0) begin
      errors++;
      $display("FAIL reset_first_rise: got valids=%0d exp 0", got_p.size());
    end
    gap(6);
    checks++;
    if (got_p.size() !== 1 || (got_p.size() == 1 && (got_d[0] !== 0 || got_c[0] !== 0))) begin
      errors++;
      $display("FAIL reset_second_rise: got valids=%0d d=%0d c=%0d exp 1 0 0", got_p.size(),
               (got_p.size() > 0) ? got_d[0] : -1, (got_p.size() > 0) ? got_c[0] : -1);
    end
    check_model("reset_mid");
  endtask

  task automatic test_random();
    int start_valids;
    do_reset();
    both_seen = 0;
    start_valids = n_valid_total;
    repeat (60) begin
      case ($urandom_range(0, 4))
        0: repeat (20) step(1'($urandom_range(0, 1)));
        1, 2: begin
          int p = $urandom_range(2, 12);
          int d = $urandom_range(0, 3);
          bit up = 1'($urandom_range(0, 1));
          repeat ($urandom_range(3, 7)) begin
            gap(p);
            p = up ? p + d : p - d;
            if (p < 2) p = 2;
          end
        end
        3: gap($urandom_range(250, 260));
        default: step(1'($urandom_range(0, 1)), 1);
      endcase
    end
    checks++;
    if (both_seen || n_valid_total - start_valids < 20) begin
      errors++;
      $display("FAIL random_sanity: got both=%0d valids=%0d exp 0 >=20",
               both_seen, n_valid_total - start_valids);
    end
    check_model("random");
  endtask

  initial begin
    in = 1'b1;
    syn_rst = 1'b1;
    n_diverge = 0;
    n_valid_total = 0;
    both_seen = 0;
    model_edge(1, 1);
    clear_obs();
    test_reset();
    test_square();
    test_ramp();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
